// File: rtl/limits_buffer_pkg.sv
// Shared types and defaults for the limits buffer RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: data width, default geometry, controller state enum, per-port
// request decode struct.
package limits_buffer_pkg;

  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  // INIT zero-fills the array after every reset; READY serves both ports.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Decoded view of one host port's request in the current cycle.
  typedef struct packed {
    logic req;  // chipselect with read or write
    logic wr;   // write requested (wins over read on the same port)
    logic rd;   // pure read (read without write)
    logic inr;  // address below DEPTH
  } port_dec_t;

endpackage

// File: rtl/limits_ram_2p.sv
// True dual-port byte-enabled word array, one clock, registered read data.
// Latency: read data valid 1 cycle after re_x; write lands at the clock edge.
// Backpressure: none; the caller guarantees no same-address write conflicts.
// Ports: per port x in {a,b}: we_x/re_x strobes, addr_x word address,
//        wdata_x/be_x write data and byte lanes, rdata_x registered read data
//        (holds its value when re_x is low). The array itself has no reset.
module limits_ram_2p
  import limits_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              we_a,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [BE_W-1:0]   be_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              we_b,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [BE_W-1:0]   be_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports share one process so the array has a single driver; the
  // controller never lets the two ports write the same word in one cycle.
  always_ff @(posedge clock) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we_a && be_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
      if (we_b && be_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
    end
    if (re_a) rdata_a <= mem[addr_a];
    if (re_b) rdata_b <= mem[addr_b];
  end

endmodule

// File: rtl/limits_buffer_ram.sv
// Two-host buffer RAM: zero-fill after reset, then dual-port byte-lane access.
// Latency: accepted read returns data 1 cycle later; readdata holds until the next read.
// Backpressure: waitrequest high during INIT and for the loser of a same-word collision.
// Ports: clock, reset_n (async, active-low); per host port x in {a,b}:
//        ram_address_x, ram_chipselect_x, ram_read_x, ram_write_x,
//        ram_writedata_x, ram_byteenable_x (bit i -> bits 8i+7:8i) in;
//        ram_readdata_x, ram_waitrequest_x out. DEPTH must be <= 2**ADDR_W.
module limits_buffer_ram
  import limits_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ram_address_a,
  input  logic              ram_chipselect_a,
  input  logic              ram_read_a,
  input  logic              ram_write_a,
  input  logic [DATA_W-1:0] ram_writedata_a,
  input  logic [BE_W-1:0]   ram_byteenable_a,
  output logic [DATA_W-1:0] ram_readdata_a,
  output logic              ram_waitrequest_a,
  input  logic [ADDR_W-1:0] ram_address_b,
  input  logic              ram_chipselect_b,
  input  logic              ram_read_b,
  input  logic              ram_write_b,
  input  logic [DATA_W-1:0] ram_writedata_b,
  input  logic [BE_W-1:0]   ram_byteenable_b,
  output logic [DATA_W-1:0] ram_readdata_b,
  output logic              ram_waitrequest_b
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              prio_b_q;     // 1: port B wins the next collision
  logic              rd_zero_a_q;  // 1: present zero instead of array data
  logic              rd_zero_b_q;
  logic              init_busy;

  port_dec_t         dec_a;
  port_dec_t         dec_b;
  logic              collide;
  logic              acc_a;
  logic              acc_b;

  logic              ram_we_a;
  logic              ram_re_a;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_wdata_a;
  logic [BE_W-1:0]   ram_be_a;
  logic [DATA_W-1:0] ram_q_a;
  logic              ram_we_b;
  logic              ram_re_b;
  logic [DATA_W-1:0] ram_q_b;

  // ---------------------------------------------------------------- decode
  always_comb begin
    dec_a.req = ram_chipselect_a & (ram_read_a | ram_write_a);
    dec_a.wr  = ram_write_a;
    dec_a.rd  = ram_read_a & ~ram_write_a;
    dec_a.inr = ({1'b0, ram_address_a} < DEPTH_X);
    dec_b.req = ram_chipselect_b & (ram_read_b | ram_write_b);
    dec_b.wr  = ram_write_b;
    dec_b.rd  = ram_read_b & ~ram_write_b;
    dec_b.inr = ({1'b0, ram_address_b} < DEPTH_X);
  end

  // Same in-range word with at least one writer. Out-of-range accesses never
  // touch the array, so they cannot collide. Two reads share freely.
  assign collide = dec_a.req & dec_b.req & dec_a.inr &
                   (ram_address_a == ram_address_b) & (dec_a.wr | dec_b.wr);

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_cnt_q == LAST_ADDR) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    init_busy         = (state_q == ST_INIT);
    ram_waitrequest_a = init_busy | (collide &  prio_b_q);
    ram_waitrequest_b = init_busy | (collide & ~prio_b_q);
  end

  assign acc_a = ~init_busy & dec_a.req & ~ram_waitrequest_a;
  assign acc_b = ~init_busy & dec_b.req & ~ram_waitrequest_b;

  // ------------------------------------------------ init sweep and priority
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt_q <= '0;
      prio_b_q   <= 1'b0;
    end else begin
      if (init_busy) begin
        init_cnt_q <= (init_cnt_q == LAST_ADDR) ? '0 : init_cnt_q + 1'b1;
      end
      // B losing hands it the next collision; the flag drops as soon as B
      // gets a transfer through, so whichever port just stalled never
      // stalls again in the following cycle.
      if (!init_busy) begin
        if (collide && !prio_b_q)     prio_b_q <= 1'b1;
        else if (prio_b_q && acc_b)   prio_b_q <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------ read data select
  // The array output register has no reset, so a flag masks it to zero after
  // reset and for out-of-range reads; both update only on accepted reads so
  // readdata holds between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_zero_a_q <= 1'b1;
      rd_zero_b_q <= 1'b1;
    end else begin
      if (acc_a && dec_a.rd) rd_zero_a_q <= ~dec_a.inr;
      if (acc_b && dec_b.rd) rd_zero_b_q <= ~dec_b.inr;
    end
  end

  assign ram_readdata_a = rd_zero_a_q ? '0 : ram_q_a;
  assign ram_readdata_b = rd_zero_b_q ? '0 : ram_q_b;

  // --------------------------------------------------------- array control
  // Port A of the array doubles as the zero-fill port during INIT.
  always_comb begin
    ram_we_a    = init_busy | (acc_a & dec_a.wr & dec_a.inr);
    ram_re_a    = acc_a & dec_a.rd & dec_a.inr;
    ram_addr_a  = init_busy ? init_cnt_q : ram_address_a;
    ram_wdata_a = init_busy ? '0 : ram_writedata_a;
    ram_be_a    = init_busy ? '1 : ram_byteenable_a;
    ram_we_b    = acc_b & dec_b.wr & dec_b.inr;
    ram_re_b    = acc_b & dec_b.rd & dec_b.inr;
  end

  limits_ram_2p #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .we_a    (ram_we_a),
    .re_a    (ram_re_a),
    .addr_a  (ram_addr_a),
    .wdata_a (ram_wdata_a),
    .be_a    (ram_be_a),
    .rdata_a (ram_q_a),
    .we_b    (ram_we_b),
    .re_b    (ram_re_b),
    .addr_b  (ram_address_b),
    .wdata_b (ram_writedata_b),
    .be_b    (ram_byteenable_b),
    .rdata_b (ram_q_b)
  );

endmodule

// File: tb/tb_limits_buffer_ram.sv
// Scoreboard bench for limits_buffer_ram: a default 256-word instance and a
// 200-word instance. Port index 0/1 = main A/B, 2/3 = 200-word A/B.
module tb_limits_buffer_ram;

  logic clock;
  logic reset_n;

  logic        cs   [4];
  logic        rd   [4];
  logic        wr   [4];
  logic [7:0]  addr [4];
  logic [31:0] wd   [4];
  logic [3:0]  be   [4];
  logic [31:0] rdat [4];
  logic        wt   [4];

  logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic        wt_a0, wt_b0, wt_a1, wt_b1;

  always_comb begin
    rdat[0] = rd_a0; rdat[1] = rd_b0; rdat[2] = rd_a1; rdat[3] = rd_b1;
    wt[0]   = wt_a0; wt[1]   = wt_b0; wt[2]   = wt_a1; wt[3]   = wt_b1;
  end

  limits_buffer_ram u_dut (
    .clock(clock), .reset_n(reset_n),
    .ram_address_a(addr[0]), .ram_chipselect_a(cs[0]), .ram_read_a(rd[0]),
    .ram_write_a(wr[0]), .ram_writedata_a(wd[0]), .ram_byteenable_a(be[0]),
    .ram_readdata_a(rd_a0), .ram_waitrequest_a(wt_a0),
    .ram_address_b(addr[1]), .ram_chipselect_b(cs[1]), .ram_read_b(rd[1]),
    .ram_write_b(wr[1]), .ram_writedata_b(wd[1]), .ram_byteenable_b(be[1]),
    .ram_readdata_b(rd_b0), .ram_waitrequest_b(wt_b0)
  );

  limits_buffer_ram #(.DEPTH(200), .ADDR_W(8)) u_dut200 (
    .clock(clock), .reset_n(reset_n),
    .ram_address_a(addr[2]), .ram_chipselect_a(cs[2]), .ram_read_a(rd[2]),
    .ram_write_a(wr[2]), .ram_writedata_a(wd[2]), .ram_byteenable_a(be[2]),
    .ram_readdata_a(rd_a1), .ram_waitrequest_a(wt_a1),
    .ram_address_b(addr[3]), .ram_chipselect_b(cs[3]), .ram_read_b(rd[3]),
    .ram_write_b(wr[3]), .ram_writedata_b(wd[3]), .ram_byteenable_b(be[3]),
    .ram_readdata_b(rd_b1), .ram_waitrequest_b(wt_b1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit          cs;
    bit          rd;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] ex;
  } op_t;

  typedef struct {
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t expq[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  bit   pend [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic op_t op_idle();
    op_t o;
    o.cs = 0; o.rd = 0; o.wr = 0; o.addr = '0; o.wd = '0; o.be = '0; o.ex = '0;
    return o;
  endfunction

  function automatic op_t op_rd(input logic [7:0] a, input logic [31:0] ex);
    op_t o;
    o = op_idle(); o.cs = 1; o.rd = 1; o.addr = a; o.ex = ex;
    return o;
  endfunction

  function automatic op_t op_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    op_t o;
    o = op_idle(); o.cs = 1; o.wr = 1; o.addr = a; o.wd = d; o.be = b;
    return o;
  endfunction

  function automatic op_t op_rw(input logic [7:0] a, input logic [31:0] d);
    op_t o;
    o = op_wr(a, d, 4'hF); o.rd = 1;
    return o;
  endfunction

  // Scoreboard monitor: a read accepted in the cycle seen at one falling edge
  // is checked against the oldest expectation for that port at the next one.
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) begin
        int idx;
        idx = -1;
        for (int j = 0; j < expq.size(); j++) begin
          if (expq[j].port == i) begin idx = j; break; end
        end
        if (idx < 0) begin
          vec_cnt++; err_cnt++;
          $display("FAIL rd_port%0d: got %h, want no read", i, rdat[i]);
        end else begin
          chk($sformatf("rd_port%0d", i), rdat[i], expq[idx].val);
          expq.delete(idx);
        end
      end
      pend[i] = reset_n && cs[i] && rd[i] && !wr[i] && !wt[i];
    end
  end

  task automatic apply(input int p, input op_t o);
    exp_t e;
    cs[p] = o.cs; rd[p] = o.rd; wr[p] = o.wr;
    addr[p] = o.addr; wd[p] = o.wd; be[p] = o.be;
    if (o.cs && o.rd && !o.wr) begin
      e.port = p; e.val = o.ex;
      expq.push_back(e);
    end
  endtask

  // Issue one op per port of instance d, hold each until accepted; return the
  // number of stalled cycles seen per port. Entered and left at posedge+1.
  task automatic run(input int d, input op_t oa, input op_t ob, output int sa, output int sb);
    int pa, pb;
    bit pend_a, pend_b, st_a, st_b;
    pa = 2 * d; pb = pa + 1;
    apply(pa, oa); apply(pb, ob);
    pend_a = oa.cs; pend_b = ob.cs; sa = 0; sb = 0;
    for (int k = 0; k < 8 && (pend_a || pend_b); k++) begin
      #1;
      st_a = pend_a && wt[pa];
      st_b = pend_b && wt[pb];
      if (st_a) sa++;
      if (st_b) sb++;
      @(posedge clock); #1;
      if (pend_a && !st_a) begin cs[pa] = 0; pend_a = 0; end
      if (pend_b && !st_b) begin cs[pb] = 0; pend_b = 0; end
    end
    if (pend_a || pend_b) begin
      vec_cnt++; err_cnt++;
      $display("FAIL run_timeout: got stalled, want accepted");
      cs[pa] = 0; cs[pb] = 0;
    end
  endtask

  // Assert reset one cycle, check reset outputs, then count INIT cycles with
  // both main ports requesting.
  task automatic reset_count(input string nm);
    int n;
    for (int i = 0; i < 4; i++) cs[i] = 0;
    reset_n = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_wait%0d", nm, i), {31'b0, wt[i]}, 32'd1);
      chk($sformatf("%s_rdat%0d", nm, i), rdat[i], 32'd0);
    end
    @(posedge clock); #1;
    reset_n = 1;
    cs[0] = 1; rd[0] = 1; wr[0] = 0; addr[0] = 8'd3;
    cs[1] = 1; rd[1] = 1; wr[1] = 0; addr[1] = 8'd4;
    n = 0;
    while (wt[0] && n < 1000) begin
      n++;
      @(posedge clock); #1;
    end
    cs[0] = 0; cs[1] = 0; rd[0] = 0; rd[1] = 0;
    chk({nm, "_init_cycles"}, n, 256);
    chk({nm, "_wait_b_after"}, {31'b0, wt[1]}, 32'd0);
    chk({nm, "_rdat_a_after"}, rdat[0], 32'd0);
  endtask

  int sa, sb;

  initial begin
    reset_n = 0;
    for (int i = 0; i < 4; i++) begin
      cs[i] = 0; rd[i] = 0; wr[i] = 0; addr[i] = '0; wd[i] = '0; be[i] = '0; pend[i] = 0;
    end
    repeat (2) @(posedge clock);
    #1;
    reset_count("por");

    // zero-filled contents
    run(0, op_rd(8'd0, 32'h0), op_rd(8'd255, 32'h0), sa, sb);
    run(0, op_rd(8'd128, 32'h0), op_idle(), sa, sb);

    // byte lanes
    run(0, op_wr(8'd5, 32'hDEADBEEF, 4'hF), op_idle(), sa, sb);
    run(0, op_wr(8'd5, 32'h00000011, 4'h1), op_idle(), sa, sb);
    run(0, op_idle(), op_rd(8'd5, 32'hDEADBE11), sa, sb);
    run(0, op_wr(8'd5, 32'hFFFFFFFF, 4'h0), op_idle(), sa, sb);
    run(0, op_wr(8'd6, 32'hAABBCCDD, 4'hA), op_rd(8'd5, 32'hDEADBE11), sa, sb);
    run(0, op_rd(8'd6, 32'hAA00CC00), op_idle(), sa, sb);

    // write/read collision: B stalls once, then sees the written word
    run(0, op_wr(8'd9, 32'h12345678, 4'hF), op_rd(8'd9, 32'h12345678), sa, sb);
    chk("coll_stall_a", sa, 0);
    chk("coll_stall_b", sb, 1);

    // both ports writing word 9 continuously: winner alternates
    for (int k = 0; k < 4; k++) begin
      cs[0] = 1; wr[0] = 1; rd[0] = 0; addr[0] = 8'd9; be[0] = 4'hF; wd[0] = 32'hA0000000 | k;
      cs[1] = 1; wr[1] = 1; rd[1] = 0; addr[1] = 8'd9; be[1] = 4'hF; wd[1] = 32'hB0000000 | k;
      #1;
      chk($sformatf("alt_wait_a%0d", k), {31'b0, wt[0]}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("alt_wait_b%0d", k), {31'b0, wt[1]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      @(posedge clock); #1;
    end
    cs[0] = 0; cs[1] = 0; wr[0] = 0; wr[1] = 0;
    run(0, op_rd(8'd9, 32'hB0000003), op_idle(), sa, sb);

    // priority back at A: B write loses to A read
    run(0, op_rd(8'd9, 32'hB0000003), op_wr(8'd9, 32'h0BADF00D, 4'hF), sa, sb);
    chk("prio_stall_a", sa, 0);
    chk("prio_stall_b", sb, 1);
    run(0, op_idle(), op_rd(8'd9, 32'h0BADF00D), sa, sb);

    // concurrent reads of one word
    run(0, op_wr(8'd200, 32'hCAFEF00D, 4'hF), op_idle(), sa, sb);
    run(0, op_rd(8'd200, 32'hCAFEF00D), op_rd(8'd200, 32'hCAFEF00D), sa, sb);
    chk("dual_rd_stall_a", sa, 0);
    chk("dual_rd_stall_b", sb, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("hold_a", rdat[0], 32'hCAFEF00D);
    chk("hold_b", rdat[1], 32'hCAFEF00D);

    // read+write together: write only, readdata unchanged
    run(0, op_rw(8'd7, 32'h00000077), op_idle(), sa, sb);
    #1;
    chk("rw_keeps_rdat", rdat[0], 32'hCAFEF00D);
    @(posedge clock); #1;
    run(0, op_rd(8'd7, 32'h00000077), op_idle(), sa, sb);

    // 200-word instance: out-of-range access
    run(1, op_wr(8'd250, 32'h55555555, 4'hF), op_rd(8'd250, 32'h0), sa, sb);
    chk("oor_stall_a", sa, 0);
    chk("oor_stall_b", sb, 0);
    run(1, op_wr(8'd199, 32'h0199ABCD, 4'hF), op_idle(), sa, sb);
    run(1, op_rd(8'd199, 32'h0199ABCD), op_idle(), sa, sb);
    run(1, op_rd(8'd250, 32'h0), op_rd(8'd199, 32'h0199ABCD), sa, sb);
    run(1, op_wr(8'd199, 32'h0000FFFF, 4'h3), op_rd(8'd199, 32'h0199FFFF), sa, sb);
    chk("edge_stall_b", sb, 1);

    // streaming writes interrupted by reset
    for (int i = 0; i < 6; i++) begin
      cs[0] = 1; wr[0] = 1; rd[0] = 0; addr[0] = 8'(10 + i); wd[0] = 32'h1000 + i; be[0] = 4'hF;
      @(posedge clock); #1;
    end
    wr[0] = 0;
    reset_count("midrst");
    run(0, op_rd(8'd10, 32'h0), op_rd(8'd5, 32'h0), sa, sb);
    run(0, op_rd(8'd200, 32'h0), op_idle(), sa, sb);

    repeat (2) @(posedge clock);
    #1;
    chk("sb_drain", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
